vga_timing_monitor: RTL and testbench
=====================================

// Module: vga_timing_monitor
// PURPOSE
//   Synthesizable, parametrised checker for any VGA-style sync/RGB stream.
//   Measures hsync and vsync period and width, and checks that RGB is zero in
//   the blanking intervals. Reports sticky per-class errors, a lock indication
//   and a frame counter.
//   Sits beside the RAM-to-VGA top level and taps its red/green/blue/hsync/vsync
//   outputs; used both in self-checking benches and on hardware driving LEDs/ILA.
// PARAMETERS
//   H_VISIBLE   640  visible pixels per line
//   H_FRONT     16   horizontal front porch (clocks)
//   H_SYNC      96   hsync pulse width (clocks)
//   H_BACK      48   horizontal back porch (clocks)
//   V_VISIBLE   480  visible lines per frame
//   V_FRONT     10   vertical front porch (lines)
//   V_SYNC      2    vsync pulse width (lines)
//   V_BACK      33   vertical back porch (lines)
//   SYNC_POL    0    asserted sync level (0 = active-low)
//   COLOR_W     4    bits per colour channel
//   LOCK_FRAMES 2    consecutive clean frames required for lock (>=1)
//   CNT_W       12   width of the internal h/v counters (saturating)
// PORTS
//   clock        in   1        pixel clock; all inputs are synchronous to it
//   reset_n      in   1        asynchronous, active-low reset
//   red          in   COLOR_W  monitored red
//   green        in   COLOR_W  monitored green
//   blue         in   COLOR_W  monitored blue
//   hsync        in   1        monitored hsync
//   vsync        in   1        monitored vsync
//   err_clear    in   1        one-cycle pulse; clears all err_* flags
//   locked       out  1        timing locked
//   err_hperiod  out  1        sticky: wrong line length
//   err_hwidth   out  1        sticky: wrong hsync width
//   err_vperiod  out  1        sticky: wrong frame length (in lines)
//   err_vwidth   out  1        sticky: wrong vsync width (in lines)
//   err_blank    out  1        sticky: non-zero RGB during blanking
//   frame_count  out  16       vsync leading edges seen, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset: all outputs 0; counters 0; h_armed = v_armed = 0; state ACQUIRE.
//   Edges: previous sync levels are registered. Leading edge = sample at
//     SYNC_POL with previous sample !SYNC_POL. Trailing edge is the reverse.
//   hcnt: 0 on an hsync-leading-edge cycle, else +1, saturating at all-ones.
//     Leading edge with h_armed: err_hperiod if prev hcnt != H_TOTAL-1.
//     Then h_armed <= 1.
//     Trailing edge with h_armed: err_hwidth if hcnt != H_SYNC.
//   vcnt (in lines): 0 on a vsync-leading-edge cycle. Otherwise +1 on each
//     hsync leading edge, saturating.
//     vsync leading edge with v_armed: err_vperiod if vcnt != V_TOTAL-1.
//     Then v_armed <= 1.
//     vsync trailing edge with v_armed: err_vwidth if vcnt != V_SYNC.
//   Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_*
//     parameters.
//   Visible window (both armed):
//     hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE), and
//     vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE).
//     Outside this window, any non-zero red/green/blue sets err_blank.
//     No blank check runs before both h_armed and v_armed are set.
//   Error flags are registered, so they are visible the cycle after the
//     offending sample. They stay set until err_clear.
//     If err_clear and a new error occur in the same cycle, the flag is set.
//   Lock FSM (evaluated on vsync leading edges; frame = interval between two):
//     ACQUIRE: first vsync leading edge -> CHECK with clean_cnt = 0.
//     CHECK:   error-free frame -> clean_cnt+1; reaching LOCK_FRAMES -> LOCKED.
//              Any error event in the frame -> clean_cnt = 0, stay in CHECK.
//     LOCKED:  locked = 1. Any error event (not flag level) -> ACQUIRE,
//              locked = 0 on the next cycle.
//     err_clear does not affect the FSM.
//   frame_count: +1 on every vsync leading edge, including the first;
//     saturating.
//   Reset mid-frame: immediate return to the reset state. The first edges
//     afterwards are not checked.
// TESTING
//   1. Ideal 640x480 generator, 3 frames:
//      locked=1 right after the 3rd vsync leading edge, all err_*=0,
//      frame_count=3.
//   2. One line with 801 clocks:
//      err_hperiod=1 one cycle after that hsync edge, locked drops, then
//      relocks after 2 clean frames.
//   3. hsync pulse of 95 clocks:
//      err_hwidth=1 only; pulse err_clear -> flag 0, stays 0 on clean frames.
//   4. RGB = 12'h00F at hcnt=H_SYNC+H_BACK-1, and separately at
//      vcnt=V_SYNC+V_BACK-1:
//      err_blank=1 each time.
//      Same value at the first visible pixel: no error.
//   5. Frame with 524 lines, then a frame with 3-line vsync:
//      err_vperiod=1, then err_vwidth=1.
//   6. Assert reset_n=0 mid-frame, release:
//      all outputs 0; the first partial line/frame raises no error.
//      SYNC_POL=1 variant passes scenario 1.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Passive VGA timing checker: hsync/vsync period and width, RGB-in-blanking, lock state and frame count.
// Flags and lock state update one clock after the offending sample; the monitored stream is never stalled.
module vga_timing_monitor #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   COLOR_W     = 4,
  parameter int   LOCK_FRAMES = 2,
  parameter int   CNT_W       = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COLOR_W-1:0] red,
  input  logic [COLOR_W-1:0] green,
  input  logic [COLOR_W-1:0] blue,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               err_clear,
  output logic               locked,
  output logic               err_hperiod,
  output logic               err_hwidth,
  output logic               err_vperiod,
  output logic               err_vwidth,
  output logic               err_blank,
  output logic [15:0]        frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_VIS_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_VIS_HI = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_VIS_HI = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);
  localparam int CLEAN_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {ACQUIRE, CHECK, LOCKED} state_t;

  state_t             state_q, state_d;
  logic               hs_on_q, vs_on_q;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic               h_armed_q, h_armed_d, v_armed_q, v_armed_d;
  logic [CLEAN_W-1:0] clean_q, clean_d;
  logic               frame_err_q, frame_err_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [4:0]         err_q, err_d;
  logic               hs_on, vs_on, hs_lead, hs_trail, vs_lead, vs_trail;
  logic [4:0]         ev;
  logic               visible, any_ev;

  always_comb begin
    hs_on    = (hsync == SYNC_POL);
    vs_on    = (vsync == SYNC_POL);
    hs_lead  = hs_on & ~hs_on_q;
    hs_trail = ~hs_on & hs_on_q;
    vs_lead  = vs_on & ~vs_on_q;
    vs_trail = ~vs_on & vs_on_q;

    // hcnt_d/vcnt_d are the counts belonging to the current sample; the _q values are the previous sample's.
    hcnt_d = hs_lead ? '0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 1'b1);
    vcnt_d = vcnt_q;
    if (vs_lead) begin
      vcnt_d = '0;
    end else if (hs_lead && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 1'b1;
    end

    visible = (hcnt_d >= H_VIS_LO) && (hcnt_d < H_VIS_HI) &&
              (vcnt_d >= V_VIS_LO) && (vcnt_d < V_VIS_HI);

    ev[4] = hs_lead  & h_armed_q & (hcnt_q != H_LAST);
    ev[3] = hs_trail & h_armed_q & (hcnt_d != H_SYNC_C);
    ev[2] = vs_lead  & v_armed_q & (vcnt_q != V_LAST);
    ev[1] = vs_trail & v_armed_q & (vcnt_d != V_SYNC_C);
    ev[0] = h_armed_q & v_armed_q & ~visible & (|{red, green, blue});
    any_ev = |ev;

    err_d     = ev | (err_q & {5{~err_clear}});
    h_armed_d = h_armed_q | hs_lead;
    v_armed_d = v_armed_q | vs_lead;
    frame_count_d = (vs_lead && (frame_count_q != 16'hFFFF)) ? frame_count_q + 16'd1 : frame_count_q;

    state_d     = state_q;
    clean_d     = clean_q;
    frame_err_d = vs_lead ? 1'b0 : (frame_err_q | any_ev);
    case (state_q)
      ACQUIRE: begin
        if (vs_lead) begin
          state_d = CHECK;
          clean_d = '0;
        end
      end
      CHECK: begin
        if (vs_lead) begin
          if (frame_err_q || any_ev) begin
            clean_d = '0;
          end else if (clean_q == CLEAN_LAST) begin
            state_d = LOCKED;
            clean_d = '0;
          end else begin
            clean_d = clean_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (any_ev) state_d = ACQUIRE;
      end
      default: state_d = ACQUIRE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // Syncs read as already asserted out of reset, so a release mid-pulse cannot fake a leading edge.
      hs_on_q       <= 1'b1;
      vs_on_q       <= 1'b1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      h_armed_q     <= 1'b0;
      v_armed_q     <= 1'b0;
      clean_q       <= '0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      err_q         <= '0;
      state_q       <= ACQUIRE;
    end else begin
      hs_on_q       <= hs_on;
      vs_on_q       <= vs_on;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      h_armed_q     <= h_armed_d;
      v_armed_q     <= v_armed_d;
      clean_q       <= clean_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
      state_q       <= state_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign err_hperiod = err_q[4];
  assign err_hwidth  = err_q[3];
  assign err_vperiod = err_q[2];
  assign err_vwidth  = err_q[1];
  assign err_blank   = err_q[0];
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: a shrunken raster drives an active-low and an active-high instance;
// a timestamp-based reference model feeds a per-cycle scoreboard, plus milestone checks at scenario ends.
module tb_vga_timing_monitor;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 2;
  localparam int H_TOTAL = HV + HF + HS + HB;
  localparam int V_TOTAL = VV + VF + VS + VB;
  localparam int LOCK_FRAMES = 2;

  typedef struct packed {
    logic        locked;
    logic [4:0]  err;   // {hperiod, hwidth, vperiod, vwidth, blank}
    logic [15:0] fc;
  } obs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n = 1'b0;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic       hs_n = 1'b1, vs_n = 1'b1, hs_p = 1'b0, vs_p = 1'b0;
  logic       err_clear = 1'b0;

  logic        lk0, hp0, hw0, vp0, vw0, bl0, lk1, hp1, hw1, vp1, vw1, bl1;
  logic [15:0] fc0, fc1;
  obs_t        act0, act1;
  assign act0 = {lk0, hp0, hw0, vp0, vw0, bl0, fc0};
  assign act1 = {lk1, hp1, hw1, vp1, vw1, bl1, fc1};

  vga_timing_monitor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .COLOR_W(4), .LOCK_FRAMES(LOCK_FRAMES), .CNT_W(8)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .red(red), .green(green), .blue(blue),
    .hsync(hs_n), .vsync(vs_n), .err_clear(err_clear), .locked(lk0),
    .err_hperiod(hp0), .err_hwidth(hw0), .err_vperiod(vp0), .err_vwidth(vw0),
    .err_blank(bl0), .frame_count(fc0)
  );

  vga_timing_monitor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b1), .COLOR_W(4), .LOCK_FRAMES(LOCK_FRAMES), .CNT_W(8)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .red(red), .green(green), .blue(blue),
    .hsync(hs_p), .vsync(vs_p), .err_clear(err_clear), .locked(lk1),
    .err_hperiod(hp1), .err_hwidth(hw1), .err_vperiod(vp1), .err_vwidth(vw1),
    .err_blank(bl1), .frame_count(fc1)
  );

  obs_t exp_q[$];
  int   n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s @%0t: got locked=%0b err=%05b frames=%0d, expected locked=%0b err=%05b frames=%0d",
               name, $time, act.locked, act.err, act.fc, exp.locked, exp.err, exp.fc);
    end
  endtask

  always @(posedge clock) begin
    obs_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare("scoreboard active-low", act0, e);
      compare("scoreboard active-high", act1, e);
    end
  end

  // Reference model: line position from the timestamp of the last hsync leading edge,
  // line index from the number of hsync leading edges since the last vsync leading edge.
  int        t = 0, t_hlead = 0, n_hlead = 0, n_at_vlead = 0, m_clean = -1, m_frames = 0;
  bit        m_hs_prev = 1'b1, m_vs_prev = 1'b1, m_harm = 1'b0, m_varm = 1'b0;
  bit        m_locked = 1'b0, m_dirty = 1'b0;
  bit  [4:0] m_err = '0;

  task automatic model_step(input bit rst, input bit hs, input bit vs, input logic [11:0] rgb, input bit clr);
    bit   hl, ht, vl, vt, vis, any;
    bit   [4:0] ev;
    int   pos, lines_before, lines_now;
    obs_t e;
    t++;
    if (rst) begin
      m_hs_prev = 1'b1; m_vs_prev = 1'b1; m_harm = 1'b0; m_varm = 1'b0;
      m_err = '0; m_locked = 1'b0; m_clean = -1; m_dirty = 1'b0; m_frames = 0;
      n_hlead = 0; n_at_vlead = 0; t_hlead = t;
      exp_q.push_back('0);
      return;
    end
    hl = hs && !m_hs_prev;  ht = !hs && m_hs_prev;
    vl = vs && !m_vs_prev;  vt = !vs && m_vs_prev;
    lines_before = n_hlead - n_at_vlead;
    if (hl) n_hlead++;
    lines_now = vl ? 0 : n_hlead - n_at_vlead;
    pos = hl ? 0 : t - t_hlead;
    vis = (pos >= HS + HB) && (pos < HS + HB + HV) && (lines_now >= VS + VB) && (lines_now < VS + VB + VV);
    ev[4] = hl && m_harm && ((t - t_hlead) != H_TOTAL);
    ev[3] = ht && m_harm && (pos != HS);
    ev[2] = vl && m_varm && (lines_before != V_TOTAL - 1);
    ev[1] = vt && m_varm && (lines_now != VS);
    ev[0] = m_harm && m_varm && !vis && (rgb != 12'h000);
    any = |ev;
    m_err = ev | (clr ? 5'b0 : m_err);
    if (m_locked) begin
      if (any) begin m_locked = 1'b0; m_clean = -1; end
    end else if (vl) begin
      if (m_clean < 0 || m_dirty || any) m_clean = 0;
      else begin
        m_clean++;
        if (m_clean == LOCK_FRAMES) m_locked = 1'b1;
      end
    end
    m_dirty = vl ? 1'b0 : (m_dirty | any);
    if (vl && m_frames < 65535) m_frames++;
    if (hl) begin t_hlead = t; m_harm = 1'b1; end
    if (vl) begin n_at_vlead = n_hlead; m_varm = 1'b1; end
    m_hs_prev = hs; m_vs_prev = vs;
    e = {m_locked, m_err, 16'(m_frames)};
    exp_q.push_back(e);
  endtask

  bit clr_next = 1'b0, clr_rate = 1'b0;
  int rst_cnt = 0, rst_line = -1, rst_px = 0;

  task automatic drive(input bit hs, input bit vs, input logic [11:0] rgb);
    bit clr, rst;
    @(negedge clock);
    rst = (rst_cnt > 0);
    if (rst_cnt > 0) rst_cnt--;
    clr = clr_next | (clr_rate & ($urandom_range(0, 31) == 0));
    clr_next = 1'b0;
    reset_n = ~rst;
    err_clear = clr;
    hs_p = hs; vs_p = vs; hs_n = ~hs; vs_n = ~vs;
    {red, green, blue} = rgb;
    model_step(rst, hs, vs, rgb, clr);
  endtask

  task automatic run_frame(input int n_lines, input int vs_lines, input int bad_line, input int bad_len,
                           input int bad_hsw, input int poke_line, input int poke_px, input logic [11:0] poke_rgb);
    for (int line = 0; line < n_lines; line++) begin
      int len, hsw;
      len = (line == bad_line) ? bad_len : H_TOTAL;
      hsw = (line == bad_line) ? bad_hsw : HS;
      for (int x = 0; x < len; x++) begin
        logic [11:0] rgb;
        bit vis;
        vis = (x >= HS + HB) && (x < HS + HB + HV) && (line >= VS + VB) && (line < VS + VB + VV);
        rgb = vis ? 12'($urandom_range(1, 4095)) : 12'h000;
        if (line == poke_line && x == poke_px) rgb = poke_rgb;
        if (line == rst_line && x == rst_px) rst_cnt = 3;
        drive(x < hsw, line < vs_lines, rgb);
      end
    end
  endtask

  task automatic clean_frame();
    run_frame(V_TOTAL, VS, -1, H_TOTAL, HS, -1, 0, 12'h000);
  endtask

  task automatic milestone(input string name, input logic lk, input logic [4:0] er, input int fc);
    obs_t e;
    @(posedge clock);
    #3;
    e = {lk, er, 16'(fc)};
    compare(name, act0, e);
    compare(name, act1, e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, got no summary, expected completion");
    $fatal(1);
  end

  initial begin
    rst_cnt = 3;
    repeat (3) drive(1'b0, 1'b0, 12'h000);
    milestone("reset state", 1'b0, 5'b00000, 0);
    repeat (4) drive(1'b0, 1'b0, 12'h000);

    repeat (3) clean_frame();
    milestone("ideal lock", 1'b1, 5'b00000, 3);

    run_frame(V_TOTAL, VS, 3, H_TOTAL + 1, HS, -1, 0, 12'h000);
    milestone("long line", 1'b0, 5'b10000, 4);
    repeat (3) clean_frame();
    milestone("relock after long line", 1'b1, 5'b10000, 7);

    clr_next = 1'b1;
    run_frame(V_TOTAL, VS, 2, H_TOTAL, HS - 1, -1, 0, 12'h000);
    milestone("short hsync", 1'b0, 5'b01000, 8);
    clr_next = 1'b1;
    repeat (2) clean_frame();
    milestone("cleared stays clear", 1'b0, 5'b00000, 10);

    clr_next = 1'b1;
    run_frame(V_TOTAL, VS, -1, H_TOTAL, HS, VS + VB + 1, HS + HB - 1, 12'h00F);
    milestone("rgb in h back porch", 1'b0, 5'b00001, 11);
    clr_next = 1'b1;
    run_frame(V_TOTAL, VS, -1, H_TOTAL, HS, VS + VB - 1, HS + HB + 1, 12'h00F);
    milestone("rgb in v back porch", 1'b0, 5'b00001, 12);
    clr_next = 1'b1;
    run_frame(V_TOTAL, VS, -1, H_TOTAL, HS, VS + VB, HS + HB, 12'h00F);
    milestone("rgb at first visible pixel", 1'b0, 5'b00000, 13);

    clr_next = 1'b1;
    run_frame(V_TOTAL + 1, VS, -1, H_TOTAL, HS, -1, 0, 12'h000);
    milestone("long frame pending", 1'b0, 5'b00000, 14);
    run_frame(V_TOTAL, VS + 1, -1, H_TOTAL, HS, -1, 0, 12'h000);
    milestone("vperiod then vwidth", 1'b0, 5'b00110, 15);

    clr_next = 1'b1;
    rst_line = 5; rst_px = 1;
    clean_frame();
    rst_line = -1;
    milestone("after mid-frame reset", 1'b0, 5'b00000, 0);
    repeat (3) clean_frame();
    milestone("relock after reset", 1'b1, 5'b00000, 3);

    clr_rate = 1'b1;
    repeat (8) begin
      int kind, bl;
      kind = $urandom_range(0, 4);
      bl = $urandom_range(0, V_TOTAL - 1);
      case (kind)
        1: run_frame(V_TOTAL, VS, bl, $urandom_range(H_TOTAL - 1, H_TOTAL + 1), HS, -1, 0, 12'h000);
        2: run_frame(V_TOTAL, VS, bl, H_TOTAL, $urandom_range(1, HS + 1), -1, 0, 12'h000);
        3: run_frame(V_TOTAL, VS, -1, H_TOTAL, HS, bl, $urandom_range(0, H_TOTAL - 1), 12'($urandom_range(0, 4095)));
        4: run_frame($urandom_range(V_TOTAL - 1, V_TOTAL + 1), $urandom_range(1, VS + 1), -1, H_TOTAL, HS, -1, 0, 12'h000);
        default: clean_frame();
      endcase
    end
    clr_rate = 1'b0;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
    #5;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
